burst_sequencer: RTL and testbench
==================================

// Module: burst_sequencer
// PURPOSE
//  Upstream control stage for the 32-count pulse counter. Issues init/en to it and consumes its co.
//  Runs a programmed number of count bursts, each separated by an idle gap.
//  Raises done when the last burst's co returns.
//  Sits between the host control logic (start/bursts) and the counter (init/en/co).
// PARAMETERS
//  CNT_W       8   width of bursts input and burst_idx output
//  GAP_CYCLES  3   cycles with en_out low between a co and the next init; 0 = no gap
//  TIMEOUT     64  watchdog limit, in RUN cycles without co (used only with BURST_WDOG_EN)
// PORTS
//  clk        in   1      single clock; all logic on posedge clk
//  rst        in   1      synchronous reset, active high
//  start      in   1      request a sequence; sampled only in IDLE
//  bursts     in   CNT_W  number of bursts; latched when start is accepted
//  co_in      in   1      carry-out from counter; one-cycle pulse at terminal count
//  init_out   out  1      one-cycle arm pulse to the counter's init
//  en_out     out  1      count enable to the counter
//  busy       out  1      sequence in progress (ARM, RUN, GAP)
//  done       out  1      one-cycle pulse after the last burst completes
//  burst_idx  out  CNT_W  number of bursts completed in the current or last sequence
//  err        out  1      watchdog fault, sticky; tied 0 without BURST_WDOG_EN
// BEHAVIOUR
//  Reset: state=IDLE; init_out=en_out=busy=done=err=0; burst_idx=0; gap/wdog counters=0.
//  rst mid-operation: IDLE on the next edge, all outputs 0, no done pulse.
//  All outputs are registered.
//  States:
//   IDLE: start=1 with bursts!=0 -> ARM, target<=bursts, burst_idx<=0, err<=0.
//   IDLE: start=1 with bursts==0 -> DONE (no init issued).
//   ARM: init_out=1 and en_out=1 for exactly one cycle -> RUN.
//   RUN: en_out=1. On co_in=1, burst_idx<=burst_idx+1.
//    If burst_idx+1==target -> DONE; else if GAP_CYCLES==0 -> ARM; else -> GAP.
//   GAP: en_out=0; wait GAP_CYCLES cycles -> ARM.
//   DONE: done=1 for one cycle; busy=0 -> IDLE.
//   ERR: see CONFIGURATION.
//  Latency: start accepted at edge N -> init_out high in cycle N+1.
//  busy is 1 in ARM, RUN and GAP only.
//  start outside IDLE (including the DONE cycle) is ignored; it is not queued.
//  co_in outside RUN is ignored and does not change burst_idx.
//  co_in in the same cycle as rst: rst wins.
//  burst_idx never wraps: target <= 2^CNT_W-1. It holds its value in IDLE until the next accepted start.
//  bursts may change freely after start; only the latched target is used.
// CONFIGURATION
//  BURST_WDOG_EN defined:
//   A wdog counter clears on entry to RUN and counts each RUN cycle without co_in.
//   When it reaches TIMEOUT: -> ERR; err=1; en_out=0; busy=0; no done pulse.
//   ERR holds until rst, or until start=1 (clears err; same handling as start in IDLE).
//  BURST_WDOG_EN undefined: no watchdog logic; err is constant 0; RUN waits indefinitely for co_in.
// TESTING
//  1. rst 2 cycles, then start with bursts=1, real counter attached
//     -> one init_out pulse; co ~33 cycles later; done one cycle after co; burst_idx=1; busy low.
//  2. bursts=3, GAP_CYCLES=3
//     -> exactly 3 init_out pulses; en_out low for exactly 3 cycles after each of the first 2 co;
//        done after the 3rd co; burst_idx=3.
//  3. bursts=0 with start -> done=1 in the next cycle; init_out never asserted; burst_idx=0.
//  4. start pulsed during RUN -> ignored, burst count unchanged.
//     Then rst during GAP -> all outputs 0 next cycle; no done pulse.
//  5. BURST_WDOG_EN, co_in held 0 -> err=1 and en_out=0 at TIMEOUT=64 cycles after RUN entry;
//     a new start clears err and issues init.
//     Without the macro: busy stays 1 and err stays 0.
//  6. co_in pulsed in IDLE and in GAP -> burst_idx unchanged; no state change.

Source files
------------

// File: rtl/burst_sequencer.sv
// ---------------------------------------------------------------------------
// burst_sequencer
//
// Upstream control stage for the 32-count pulse counter. It issues init/en to
// the counter and consumes its carry-out. It runs a programmed number of count
// bursts, with an idle gap between bursts, and pulses done once the last
// burst's carry-out has come back.
//
// Optional feature macro: BURST_WDOG_EN
//   defined   : a watchdog counts RUN cycles without co_in. On reaching TIMEOUT
//               the sequencer enters ERR and raises a sticky err.
//   undefined : no watchdog logic, err is tied to 0, RUN waits indefinitely.
//
// Parameters
//   CNT_W       width of bursts and burst_idx
//   GAP_CYCLES  en_out-low cycles between a co_in and the next init (0 = none)
//   TIMEOUT     RUN cycles without co_in before a watchdog fault
//
// Ports
//   clk        in   single clock, all logic on posedge
//   rst        in   synchronous reset, active high
//   start      in   sequence request, sampled in IDLE (and ERR)
//   bursts     in   burst count, latched when start is accepted
//   co_in      in   counter carry-out, one-cycle pulse
//   init_out   out  one-cycle arm pulse to the counter
//   en_out     out  counter enable
//   busy       out  high in ARM, RUN and GAP
//   done       out  one-cycle pulse after the last burst
//   burst_idx  out  bursts completed in the current or last sequence
//   err        out  sticky watchdog fault
//
// All outputs are registered. They are computed from the next state, so the
// output seen in a cycle always matches the state held in that cycle.
// ---------------------------------------------------------------------------
module burst_sequencer #(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] bursts,
    input  logic             co_in,
    output logic             init_out,
    output logic             en_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] burst_idx,
    output logic             err
);

    // State encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    // The gap counter runs 0 .. GAP_CYCLES-1. With GAP_CYCLES == 0 the GAP
    // state is never entered and the counter is left idle.
    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDX_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] target_nxt_s;
    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] idx_nxt_s;
    logic [CNT_W-1:0] idx_inc_s;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_nxt_s;
    logic             init_r;
    logic             en_r;
    logic             busy_r;
    logic             done_r;

`ifdef BURST_WDOG_EN
    localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic [WDOG_W-1:0] wdog_r;
    logic [WDOG_W-1:0] wdog_nxt_s;
    logic              err_r;
    logic              err_nxt_s;
`endif

    // target never exceeds 2^CNT_W-1, so this increment cannot wrap in use
    assign idx_inc_s = idx_r + IDX_ONE;

    // Next-state and next-datapath decode
    always_comb begin
        state_nxt_s  = state_r;
        target_nxt_s = target_r;
        idx_nxt_s    = idx_r;
        gap_nxt_s    = gap_r;
`ifdef BURST_WDOG_EN
        wdog_nxt_s   = wdog_r;
        err_nxt_s    = err_r;
`endif
        case (state_r)
            // ERR only exits through start, handled exactly like IDLE
            S_IDLE, S_ERR: begin
                if (start) begin
                    idx_nxt_s = IDX_ZERO;
`ifdef BURST_WDOG_EN
                    err_nxt_s = 1'b0;
`endif
                    if (bursts != IDX_ZERO) begin
                        state_nxt_s  = S_ARM;
                        target_nxt_s = bursts;
                    end else begin
                        // zero bursts: report completion without arming
                        state_nxt_s = S_DONE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_ARM: begin
                state_nxt_s = S_RUN;
`ifdef BURST_WDOG_EN
                wdog_nxt_s  = {WDOG_W{1'b0}};
`endif
            end
            S_RUN: begin
                if (co_in) begin
                    idx_nxt_s = idx_inc_s;
                    if (idx_inc_s == target_r) begin
                        state_nxt_s = S_DONE;
                    end else if (GAP_CYCLES == 32'sd0) begin
                        state_nxt_s = S_ARM;
                    end else begin
                        state_nxt_s = S_GAP;
                        gap_nxt_s   = {GAP_W{1'b0}};
                    end
                end else begin
`ifdef BURST_WDOG_EN
                    // TIMEOUT-th consecutive RUN cycle without a carry-out
                    if (wdog_r == WDOG_LAST) begin
                        state_nxt_s = S_ERR;
                        err_nxt_s   = 1'b1;
                    end else begin
                        wdog_nxt_s  = wdog_r + WDOG_ONE;
                    end
`else
                    state_nxt_s = S_RUN;
`endif
                end
            end
            S_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_nxt_s = S_ARM;
                end else begin
                    gap_nxt_s = gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs (outputs decoded from next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            target_r <= IDX_ZERO;
            idx_r    <= IDX_ZERO;
            gap_r    <= {GAP_W{1'b0}};
            init_r   <= 1'b0;
            en_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            target_r <= target_nxt_s;
            idx_r    <= idx_nxt_s;
            gap_r    <= gap_nxt_s;
            init_r   <= (state_nxt_s == S_ARM);
            en_r     <= (state_nxt_s == S_ARM) || (state_nxt_s == S_RUN);
            busy_r   <= (state_nxt_s == S_ARM) || (state_nxt_s == S_RUN) ||
                        (state_nxt_s == S_GAP);
            done_r   <= (state_nxt_s == S_DONE);
        end
    end

`ifdef BURST_WDOG_EN
    // Watchdog counter and sticky fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_r <= {WDOG_W{1'b0}};
            err_r  <= 1'b0;
        end else begin
            wdog_r <= wdog_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign init_out  = init_r;
    assign en_out    = en_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign burst_idx = idx_r;

endmodule

// File: tb/tb_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_burst_sequencer
//
// The reference is a per-cycle plan built from the sequencing rules: each
// burst is one ARM cycle, a run of en cycles ending in a carry-out, then a gap
// of GAP cycles (none after the last burst), then one done cycle. Every plan
// entry carries the inputs to drive in that cycle and the outputs expected in
// it. Run lengths, burst counts and stray inputs are randomized.
// ---------------------------------------------------------------------------
module tb_burst_sequencer;

    localparam int CNT_W   = 8;
    localparam int GAP     = 3;
    localparam int TIMEOUT = 64;

    typedef struct {
        bit         rst;
        bit         start;
        bit         co;
        logic [7:0] bursts;
        bit         init;
        bit         en;
        bit         busy;
        bit         done;
        bit         err;
        logic [7:0] idx;
    } cyc_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] bursts;
    logic             co_in;
    logic             init_out;
    logic             en_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] burst_idx;
    logic             err;

    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;
    cyc_t       plan[$];
    logic [7:0] cur_idx = 8'd0;
    bit         cur_err = 1'b0;

    burst_sequencer #(
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bursts    (bursts),
        .co_in     (co_in),
        .init_out  (init_out),
        .en_out    (en_out),
        .busy      (busy),
        .done      (done),
        .burst_idx (burst_idx),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    task automatic check_cycle(input cyc_t e);
        check("init_out",  32'(init_out),  32'(e.init));
        check("en_out",    32'(en_out),    32'(e.en));
        check("busy",      32'(busy),      32'(e.busy));
        check("done",      32'(done),      32'(e.done));
        check("err",       32'(err),       32'(e.err));
        check("burst_idx", 32'(burst_idx), 32'(e.idx));
    endtask

    // Append one planned cycle; b < 0 means bursts is random noise
    function automatic void add(bit r, bit s, bit c, int b,
                                bit i, bit e, bit bz, bit d, bit er, logic [7:0] x);
        cyc_t t;
        t.rst    = r;
        t.start  = s;
        t.co     = c;
        t.bursts = (b < 0) ? 8'($urandom_range(0, 255)) : 8'(b);
        t.init   = i;
        t.en     = e;
        t.busy   = bz;
        t.done   = d;
        t.err    = er;
        t.idx    = x;
        plan.push_back(t);
    endfunction

    // Quiet cycles with stray carry-outs that must be ignored
    function automatic void idle(int k);
        for (int n = 0; n < k; n++)
            add(1'b0, 1'b0, 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0, 1'b0, 1'b0, cur_err, cur_idx);
    endfunction

    // One full sequence of n bursts
    function automatic void plan_seq(int n, int fixed_len, bit st_run, bit co_gap, bit rst_gap);
        int len;
        add(1'b0, 1'b1, 1'b0, n, 1'b0, 1'b0, 1'b0, 1'b0, cur_err, cur_idx);
        cur_err = 1'b0;
        if (n == 0) begin
            add(1'b0, 1'($urandom_range(0, 1)), 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
            cur_idx = 8'd0;
            idle(3);
            return;
        end
        for (int i = 0; i < n; i++) begin
            add(1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
            len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 40));
            for (int j = 1; j <= len; j++)
                add(1'b0, st_run && (j == 1), j == len, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
            if (i == n - 1) begin
                // start during the done cycle must be ignored
                add(1'b0, 1'($urandom_range(0, 1)), 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(n));
            end else begin
                for (int g = 0; g < GAP; g++) begin
                    if (rst_gap && g == 1) begin
                        add(1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i + 1));
                        cur_idx = 8'd0;
                        idle(3);
                        return;
                    end
                    add(1'b0, 1'b0, co_gap && (g == 0), -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i + 1));
                end
            end
        end
        cur_idx = 8'(n);
        idle(3);
    endfunction

    // A sequence whose counter never returns a carry-out
    function automatic void plan_hang();
        add(1'b0, 1'b1, 1'b0, int'($urandom_range(1, 5)), 1'b0, 1'b0, 1'b0, 1'b0, cur_err, cur_idx);
        cur_err = 1'b0;
        add(1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
`ifdef BURST_WDOG_EN
        for (int j = 0; j < TIMEOUT; j++)
            add(1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        cur_err = 1'b1;
        cur_idx = 8'd0;
        idle(4);
`else
        for (int j = 0; j < 150; j++)
            add(1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        // carry-out coincident with reset: reset wins
        add(1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        cur_idx = 8'd0;
        idle(3);
`endif
    endfunction

    initial begin
        cyc_t e;
        bit   rg;
        int   n;

        rst    = 1'b1;
        start  = 1'b0;
        bursts = 8'd0;
        co_in  = 1'b0;
        @(posedge clk);
        #1;
        e = '{rst: 1'b1, start: 1'b0, co: 1'b0, bursts: 8'd0, init: 1'b0, en: 1'b0,
              busy: 1'b0, done: 1'b0, err: 1'b0, idx: 8'd0};
        check_cycle(e);
        @(posedge clk);
        #1;
        rst = 1'b0;

        plan_seq(1, 32, 1'b0, 1'b0, 1'b0);   // single burst, counter-like length
        plan_seq(3, 0, 1'b0, 1'b0, 1'b0);    // three bursts with gaps
        plan_seq(0, 0, 1'b0, 1'b0, 1'b0);    // zero bursts
        plan_seq(4, 0, 1'b1, 1'b1, 1'b0);    // start in RUN, co in GAP
        plan_seq(3, 0, 1'b0, 1'b0, 1'b1);    // reset during GAP
        plan_hang();
        plan_seq(2, 0, 1'b0, 1'b0, 1'b0);    // recovery after the hang
        plan_seq(255, 1, 1'b0, 1'b1, 1'b0);  // maximum burst count
        for (int k = 0; k < 8; k++) begin
            n  = int'($urandom_range(0, 6));
            rg = (n >= 2) && ($urandom_range(0, 3) == 0);
            plan_seq(n, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rg);
        end

        while (plan.size() > 0) begin
            e = plan.pop_front();
            check_cycle(e);
            rst    = e.rst;
            start  = e.start;
            co_in  = e.co;
            bursts = e.bursts;
            @(posedge clk);
            #1;
            cycle++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
